// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl_pkg
// Brief    : Shared state type and default sizing for the counter controller.
// Revision : 1.0
// ============================================================================
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int c_default_width = 16;
    localparam int c_default_div   = 50000000;

endpackage
`default_nettype wire

// File: rtl/counter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl_if
// Brief    : Button, limit/feedback and control-output bundle of counter_ctrl.
// Revision : 1.0
// ============================================================================
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
    #(parameter int WIDTH = c_default_width);

    logic             Start;
    logic             Stop;
    logic             Clear;
    logic [WIDTH-1:0] Limit;
    logic [WIDTH-1:0] Q;
    logic             En;
    logic             CntClr;
    logic             Running;
    logic             Done;
    logic             Tick;

    modport master (
        output Start, Stop, Clear, Limit, Q,
        input  En, CntClr, Running, Done, Tick
    );

    modport slave (
        input  Start, Stop, Clear, Limit, Q,
        output En, CntClr, Running, Done, Tick
    );

endinterface
`default_nettype wire

// File: rtl/counter_ctrl_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Brief    : Rising-edge detector; reset preloads the input so held levels
//            never produce an edge when reset releases.
// Revision : 1.0
// ============================================================================
module edge_detect
    import counter_ctrl_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= din;
        end else begin
            r_prev <= din;
        end
    end

    assign rise = din & ~r_prev & ~rst;

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl
// Brief    : Run/pause/clear sequencer issuing prescaled enables to a counter
//            and stopping at a programmable limit.
//            COUNTER_CTRL_AUTORELOAD_EN: wrap to 0 at the limit instead of
//            stopping.
// Revision : 1.0
// ============================================================================
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DIV   = c_default_div
) (
    input  wire logic     CLOCK_50,
    input  wire logic     Clr,
    counter_ctrl_if.slave bus
);

    localparam int              c_pw   = $clog2(DIV);
    localparam logic [c_pw-1:0] c_last = c_pw'(DIV - 1);

    logic w_start;
    logic w_stop;
    logic w_clear;

    edge_detect u_start (.clk(CLOCK_50), .rst(Clr), .din(bus.Start), .rise(w_start));
    edge_detect u_stop  (.clk(CLOCK_50), .rst(Clr), .din(bus.Stop),  .rise(w_stop));
    edge_detect u_clear (.clk(CLOCK_50), .rst(Clr), .din(bus.Clear), .rise(w_clear));

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_pw-1:0] r_presc;
    logic [c_pw-1:0] w_presc_nxt;
    logic            w_at_limit;
    logic            w_tick;
    logic            w_restart;
    logic            w_en;
    logic            w_cnt_clr;
    logic            w_done;

    always_ff @(posedge CLOCK_50) begin
        if (Clr) begin
            r_state <= IDLE;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_at_limit  = (bus.Q == bus.Limit);
        w_tick      = !Clr && (r_state == RUN) && (r_presc == c_last);
        w_restart   = (r_state == DONE) && w_start && !w_clear;
        w_en        = w_tick && !w_at_limit && !w_clear;
        w_cnt_clr   = Clr || w_clear || w_restart;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
        // Reaching the limit on a tick reloads the counter instead of stopping.
        w_cnt_clr   = w_cnt_clr || (w_tick && w_at_limit);
        w_done      = w_tick && w_at_limit && !w_clear;
`else
        w_done      = !Clr && (r_state == DONE);
`endif

        case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = RUN;
            end
            RUN: begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                if (w_stop) w_state_nxt = PAUSE;
`else
                if (w_at_limit)  w_state_nxt = DONE;
                else if (w_stop) w_state_nxt = PAUSE;
`endif
            end
            PAUSE: begin
                if (w_start && !w_stop) w_state_nxt = RUN;
            end
            DONE: begin
                if (w_start) w_state_nxt = RUN;
            end
        endcase

        if (w_clear) w_state_nxt = IDLE;

        // Only RUN advances the prescaler, so PAUSE preserves the partial period.
        if (w_clear || w_restart || w_tick) begin
            w_presc_nxt = '0;
        end else if (r_state == RUN) begin
            w_presc_nxt = r_presc + c_pw'(1);
        end
    end

    assign bus.En      = w_en;
    assign bus.CntClr  = w_cnt_clr;
    assign bus.Tick    = w_tick;
    assign bus.Running = !Clr && (r_state == RUN);
    assign bus.Done    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_ctrl
// Brief    : Directed and randomized checks of counter_ctrl against a
//            cycle-level behavioural model with a modelled counter on Q.
// Revision : 1.0
// ============================================================================
module tb_counter_ctrl;

    localparam int DIV   = 4;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

    counter_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .CLOCK_50 (clk),
        .Clr      (clr),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: mode 0=idle 1=run 2=pause 3=done; acc counts RUN cycles toward DIV.
    int          m_mode;
    int          m_acc;
    logic        m_ps, m_pt, m_pc;
    logic [15:0] m_q;
    logic        e_en, e_tick, e_clr, e_run, e_done;

    logic        s_en, s_tick, s_clr, s_run, s_done;
    logic [15:0] dq;
    int          n_cycle;
    int          en_seen, first_en, last_en;
    int          done_seen, first_done, last_done;
    int          tick_seen;
    int          dq_max;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_eval(output int nmode, output int nacc);
        logic se, st, sc, at;
        se = bus.Start & ~m_ps;
        st = bus.Stop  & ~m_pt;
        sc = bus.Clear & ~m_pc;
        if (clr) begin
            e_en = 0; e_tick = 0; e_clr = 1; e_run = 0; e_done = 0;
            nmode = 0; nacc = 0;
            return;
        end
        at     = (m_q == bus.Limit);
        e_tick = (m_mode == 1) && (m_acc == DIV - 1);
        e_run  = (m_mode == 1);
        e_en   = e_tick && !at && !sc;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
        e_clr  = sc || (e_tick && at);
        e_done = e_tick && at && !sc;
`else
        e_clr  = sc || ((m_mode == 3) && se);
        e_done = (m_mode == 3);
`endif
        nmode = m_mode;
        nacc  = m_acc;
        if (sc) begin
            nmode = 0; nacc = 0;
        end else begin
            case (m_mode)
                0: if (se) nmode = 1;
                1: begin
                    nacc = (m_acc + 1) % DIV;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                    if (st) nmode = 2;
`else
                    if (at)      nmode = 3;
                    else if (st) nmode = 2;
`endif
                end
                2: if (se && !st) nmode = 1;
                default: if (se) begin nmode = 1; nacc = 0; end
            endcase
        end
    endtask

    // One clock: inputs already set just after the falling edge.
    task automatic cycle();
        int nm, na;
        #1;
        model_eval(nm, na);
        s_en = bus.En; s_tick = bus.Tick; s_clr = bus.CntClr;
        s_run = bus.Running; s_done = bus.Done;
        chk("en",      s_en,   e_en);
        chk("tick",    s_tick, e_tick);
        chk("cntclr",  s_clr,  e_clr);
        chk("running", s_run,  e_run);
        chk("done",    s_done, e_done);
        if (s_en)   begin en_seen++;   if (first_en < 0)   first_en = n_cycle;   last_en = n_cycle;   end
        if (s_done) begin done_seen++; if (first_done < 0) first_done = n_cycle; last_done = n_cycle; end
        if (s_tick) tick_seen++;
        @(posedge clk);
        #1;
        if (s_clr) dq = '0; else if (s_en) dq = dq + 16'd1;
        if (int'(dq) > dq_max) dq_max = int'(dq);
        if (e_clr) m_q = '0; else if (e_en) m_q = m_q + 16'd1;
        m_ps = bus.Start; m_pt = bus.Stop; m_pc = bus.Clear;
        m_mode = nm; m_acc = na;
        bus.Q = m_q;
        n_cycle++;
        @(negedge clk);
    endtask

    task automatic clear_counts();
        en_seen = 0; first_en = -1; last_en = -1;
        done_seen = 0; first_done = -1; last_done = -1;
        tick_seen = 0; dq_max = 0;
    endtask

    initial begin
        int guard;
        clr = 1; bus.Start = 1; bus.Stop = 0; bus.Clear = 0;
        bus.Limit = 16'd3; bus.Q = 16'd0;
        m_q = '0; dq = '0; m_mode = 0; m_acc = 0;
        m_ps = 1; m_pt = 0; m_pc = 0; n_cycle = 0;
        clear_counts();
        @(negedge clk);

        // Reset held with Start high, then released without an edge.
        repeat (3) begin
            cycle();
            chk("rst_cntclr", s_clr, 1'b1);
        end
        clr = 0;
        repeat (3) begin
            cycle();
            chk("rst_no_run", s_run, 1'b0);
            chk("rst_no_clr", s_clr, 1'b0);
        end
        bus.Start = 0; cycle();

`ifdef COUNTER_CTRL_AUTORELOAD_EN
        // Autoreload with limit 2: 0,1,2,0,... with a Done pulse every 12 cycles.
        bus.Limit = 16'd2;
        bus.Start = 1; cycle(); bus.Start = 0;
        clear_counts();
        guard = 0;
        repeat (36) begin
            cycle();
            if (!s_run) guard++;
        end
        chk_int("ar_done_count", done_seen, 3);
        chk_int("ar_done_span", last_done - first_done, 24);
        chk_int("ar_running_low", guard, 0);
        chk_int("ar_q_max", dq_max, 2);
        chk_int("ar_q_end", int'(dq), 0);
        bus.Clear = 1; cycle(); bus.Clear = 0; cycle();
        bus.Limit = 16'd3;
`else
        // Basic count to limit 3.
        bus.Start = 1; cycle(); bus.Start = 0;
        clear_counts();
        repeat (20) cycle();
        chk_int("basic_en_count", en_seen, 3);
        chk_int("basic_en_span", last_en - first_en, 8);
        chk_int("basic_q", int'(dq), 3);
        chk("basic_done", s_done, 1'b1);
        chk("basic_not_running", s_run, 1'b0);
        bus.Clear = 1; cycle(); bus.Clear = 0; cycle();
        chk_int("clear_q", int'(dq), 0);
`endif

        // Pause two cycles into RUN, hold, then resume mid-period.
        bus.Start = 1; cycle(); bus.Start = 0;
        cycle();
        bus.Stop = 1; cycle(); bus.Stop = 0;
        clear_counts();
        repeat (10) cycle();
        chk_int("pause_no_tick", tick_seen, 0);
        chk("pause_not_running", s_run, 1'b0);
        bus.Start = 1; cycle(); bus.Start = 0;
        cycle();
        chk("resume_en_early", s_en, 1'b0);
        cycle();
        chk("resume_en", s_en, 1'b1);

        // Clear and Stop together on the tick cycle.
        guard = 0;
        while (!(m_mode == 1 && m_acc == DIV - 1) && guard < 10) begin
            cycle(); guard++;
        end
        chk_int("clrpri_wait_ok", (guard < 10) ? 1 : 0, 1);
        bus.Clear = 1; bus.Stop = 1; cycle();
        chk("clrpri_en", s_en, 1'b0);
        chk("clrpri_cntclr", s_clr, 1'b1);
        bus.Clear = 0; bus.Stop = 0; cycle();
        chk("clrpri_idle", s_run, 1'b0);
        chk_int("clrpri_q", int'(dq), 0);

`ifndef COUNTER_CTRL_AUTORELOAD_EN
        // Restart from DONE.
        bus.Limit = 16'd1;
        bus.Start = 1; cycle(); bus.Start = 0;
        repeat (12) cycle();
        chk("rs_done", s_done, 1'b1);
        chk_int("rs_q_at_limit", int'(dq), 1);
        bus.Start = 1; cycle(); bus.Start = 0;
        chk("rs_cntclr", s_clr, 1'b1);
        cycle();
        chk("rs_running", s_run, 1'b1);
        chk_int("rs_q_zero", int'(dq), 0);
        repeat (4) cycle();
        chk_int("rs_q_counted", int'(dq), 1);

        // Limit 0: DONE one cycle after entering RUN, with no enable.
        bus.Clear = 1; cycle(); bus.Clear = 0; cycle();
        bus.Limit = 16'd0;
        clear_counts();
        bus.Start = 1; cycle(); bus.Start = 0;
        cycle();
        chk("l0_running", s_run, 1'b1);
        cycle();
        chk("l0_done", s_done, 1'b1);
        chk_int("l0_no_en", en_seen, 0);
        bus.Clear = 1; cycle(); bus.Clear = 0; cycle();
`endif

        // Randomized buttons, limits and occasional resets.
        repeat (1500) begin
            bus.Start = ($urandom_range(0, 7) == 0);
            bus.Stop  = ($urandom_range(0, 11) == 0);
            bus.Clear = ($urandom_range(0, 49) == 0);
            clr       = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) bus.Limit = 16'($urandom_range(0, 5));
            cycle();
        end
        clr = 0; bus.Start = 0; bus.Stop = 0; bus.Clear = 0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
